// File: rtl/locked_intc_pkg.sv
// Shared types and constants for the key-locked priority interrupt controller.
// The key-load FSM states, the default golden key and an index-width helper.
package locked_intc_pkg;

  typedef enum logic [1:0] {
    K_IDLE,
    K_SHIFT,
    K_CHECK
  } key_state_e;

  localparam logic [31:0] DEFAULT_GOLDEN_KEY = 32'hA5C3_1E7F;

  // Width needed to index n items; never less than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prio_enc.sv
// First-one finder: returns the lowest set bit index of i_vec and whether any bit is set.
module prio_enc
  import locked_intc_pkg::*;
#(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned IDX_W = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx   = IDX_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/locked_prio_intc.sv
// Key-locked fixed-priority interrupt controller: serial key loader, per-channel masking
// derived from the committed key, bus/channel arbitration and a valid/ready result stage.
module locked_prio_intc
  import locked_intc_pkg::*;
#(
  parameter int unsigned      NUM_BUS    = 3,
  parameter int unsigned      NUM_CH     = 9,
  parameter int unsigned      KEY_W      = 32,
  parameter logic [KEY_W-1:0] GOLDEN_KEY = KEY_W'(DEFAULT_GOLDEN_KEY),
  localparam int unsigned     CH_W       = idx_w(NUM_CH)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_key_bit_in,
  input  logic                      i_key_shift,
  input  logic                      i_key_commit,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic [NUM_BUS*NUM_CH-1:0] i_req_vec,
  input  logic [NUM_CH-1:0]         i_chan_en,
  output logic                      o_gnt_valid,
  input  logic                      i_gnt_ready,
  output logic [NUM_BUS-1:0]        o_gnt_bus,
  output logic [CH_W-1:0]           o_gnt_ch,
  output logic                      o_gnt_any,
  output logic                      o_unlocked,
  output logic                      o_key_err
);

  localparam int unsigned      BUS_W   = idx_w(NUM_BUS);
  localparam int unsigned      CNT_W   = idx_w(KEY_W + 1);
  localparam logic [CNT_W-1:0] KEY_CNT = CNT_W'(KEY_W);

  key_state_e         r_kstate, w_kstate_next;
  logic [KEY_W-1:0]   r_sr, r_key_act;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_unlocked, r_key_err;
  logic               w_do_shift;

  logic               r_gnt_valid, r_gnt_any;
  logic [NUM_BUS-1:0] r_gnt_bus;
  logic [CH_W-1:0]    r_gnt_ch;
  logic               w_accept;

  always_comb begin
    w_kstate_next = r_kstate;
    w_do_shift    = 1'b0;
    unique case (r_kstate)
      K_IDLE: begin
        // A commit without any preceding shift is ignored.
        if (i_key_shift) begin
          w_do_shift    = 1'b1;
          w_kstate_next = K_SHIFT;
        end
      end
      K_SHIFT: begin
        w_do_shift = i_key_shift;
        if (i_key_commit) w_kstate_next = K_CHECK;
      end
      K_CHECK: w_kstate_next = K_IDLE;
      default: w_kstate_next = K_IDLE;
    endcase
  end

  // A wrong key disables exactly the channels whose key bit differs from the golden key.
  logic [NUM_CH-1:0]                  w_mask;
  logic [NUM_BUS-1:0][NUM_CH-1:0]     w_eff;
  logic [NUM_BUS-1:0][CH_W-1:0]       w_ch_idx;
  logic [NUM_BUS-1:0]                 w_bus_hit;
  logic [BUS_W-1:0]                   w_bus_idx;
  logic                               w_any;
  logic [NUM_BUS-1:0]                 w_gnt_bus;
  logic [CH_W-1:0]                    w_gnt_ch;

  always_comb begin
    w_mask = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_mask[c] = ~(r_key_act[c % KEY_W] ^ GOLDEN_KEY[c % KEY_W]);
    end
  end

  for (genvar b = 0; b < NUM_BUS; b++) begin : g_bus
    assign w_eff[b] = i_req_vec[b*NUM_CH +: NUM_CH] & i_chan_en & w_mask;

    prio_enc #(
      .WIDTH (NUM_CH)
    ) u_ch_enc (
      .i_vec   (w_eff[b]),
      .o_idx   (w_ch_idx[b]),
      .o_found (w_bus_hit[b])
    );
  end

  prio_enc #(
    .WIDTH (NUM_BUS)
  ) u_bus_enc (
    .i_vec   (w_bus_hit),
    .o_idx   (w_bus_idx),
    .o_found (w_any)
  );

  always_comb begin
    w_gnt_bus = '0;
    w_gnt_ch  = '0;
    for (int b = 0; b < NUM_BUS; b++) begin
      if (w_any && (w_bus_idx == BUS_W'(b))) begin
        w_gnt_bus[b] = 1'b1;
        w_gnt_ch     = w_ch_idx[b];
      end
    end
  end

  assign o_req_ready = !r_gnt_valid || i_gnt_ready;
  assign w_accept    = i_req_valid && o_req_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_kstate    <= K_IDLE;
      r_sr        <= '0;
      r_cnt       <= '0;
      r_key_act   <= '0;
      r_unlocked  <= 1'b0;
      r_key_err   <= 1'b0;
      r_gnt_valid <= 1'b0;
      r_gnt_bus   <= '0;
      r_gnt_ch    <= '0;
      r_gnt_any   <= 1'b0;
    end else begin
      r_kstate <= w_kstate_next;
      if (w_do_shift) begin
        r_sr <= {r_sr[KEY_W-2:0], i_key_bit_in};
        if (r_cnt != KEY_CNT) r_cnt <= r_cnt + 1'b1;
      end
      if (r_kstate == K_CHECK) begin
        r_cnt <= '0;
        if (r_cnt == KEY_CNT) begin
          r_key_act <= r_sr;
          r_key_err <= 1'b0;
        end else begin
          r_key_err <= 1'b1;
        end
      end
      r_unlocked <= (r_key_act == GOLDEN_KEY);

      if (w_accept) begin
        r_gnt_valid <= 1'b1;
        r_gnt_bus   <= w_gnt_bus;
        r_gnt_ch    <= w_gnt_ch;
        r_gnt_any   <= w_any;
      end else if (i_gnt_ready) begin
        r_gnt_valid <= 1'b0;
      end
    end
  end

  assign o_gnt_valid = r_gnt_valid;
  assign o_gnt_bus   = r_gnt_bus;
  assign o_gnt_ch    = r_gnt_ch;
  assign o_gnt_any   = r_gnt_any;
  assign o_unlocked  = r_unlocked;
  assign o_key_err   = r_key_err;

endmodule

// File: tb/tb_locked_prio_intc.sv
// Scoreboard bench for locked_prio_intc: directed key/arbitration cases plus randomized
// traffic checked against a behavioural priority model.
module tb_locked_prio_intc;

  localparam int          NB   = 3;
  localparam int          NC   = 9;
  localparam logic [31:0] GOLD = 32'hA5C3_1E7F;

  typedef struct packed {
    logic [2:0] bus;
    logic [3:0] ch;
    logic       hit;
  } res_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_key_bit_in = 1'b0;
  logic        i_key_shift = 1'b0;
  logic        i_key_commit = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [26:0] i_req_vec = '0;
  logic [8:0]  i_chan_en = '1;
  logic        o_gnt_valid;
  logic        i_gnt_ready = 1'b1;
  logic [2:0]  o_gnt_bus;
  logic [3:0]  o_gnt_ch;
  logic        o_gnt_any;
  logic        o_unlocked;
  logic        o_key_err;

  locked_prio_intc u_dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_key_bit_in (i_key_bit_in),
    .i_key_shift  (i_key_shift),
    .i_key_commit (i_key_commit),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_vec    (i_req_vec),
    .i_chan_en    (i_chan_en),
    .o_gnt_valid  (o_gnt_valid),
    .i_gnt_ready  (i_gnt_ready),
    .o_gnt_bus    (o_gnt_bus),
    .o_gnt_ch     (o_gnt_ch),
    .o_gnt_any    (o_gnt_any),
    .o_unlocked   (o_unlocked),
    .o_key_err    (o_key_err)
  );

  always #5 i_clk = ~i_clk;

  res_t        sb[$];
  res_t        mon_exp;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] model_key = '0;
  logic        model_err = 1'b0;
  logic        last_acc;
  logic [26:0] rv;
  logic [8:0]  ren;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Lowest bus with an enabled, key-permitted request wins; lowest channel within it.
  function automatic res_t model(input logic [26:0] vec, input logic [8:0] en,
                                 input logic [31:0] key);
    res_t r;
    r = '0;
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < NC; c++) begin
        if (!r.hit && vec[b*NC+c] && en[c] && (key[c%32] == GOLD[c%32])) begin
          r.hit = 1'b1;
          r.bus = 3'(1 << b);
          r.ch  = 4'(c);
        end
      end
    end
    return r;
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [26:0] vec, input logic [8:0] en,
                       input logic gr, input bit use_exp, input res_t exp);
    i_req_valid = v;
    i_req_vec   = vec;
    i_chan_en   = en;
    i_gnt_ready = gr;
    #1;
    last_acc = v && o_req_ready;
    if (last_acc) sb.push_back(use_exp ? exp : model(vec, en, model_key));
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
  endtask

  task automatic load_key(input logic [31:0] k, input int nbits, input bit same_cycle);
    for (int i = 0; i < nbits; i++) begin
      i_key_bit_in = k[nbits-1-i];
      i_key_shift  = 1'b1;
      if (same_cycle && (i == nbits - 1)) i_key_commit = 1'b1;
      step();
    end
    i_key_shift = 1'b0;
    if (!same_cycle) begin
      i_key_commit = 1'b1;
      step();
    end
    i_key_commit = 1'b0;
    step();
    step();
    if (nbits == 32) begin
      model_key = k;
      model_err = 1'b0;
    end else begin
      model_err = 1'b1;
    end
    check("unlocked_after_commit", 32'(o_unlocked), 32'(model_key == GOLD));
    check("key_err_after_commit", 32'(o_key_err), 32'(model_err));
  endtask

  initial begin : monitor
    forever begin
      @(negedge i_clk);
      if (!i_rst && o_gnt_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got bus %b ch %0d with nothing pending",
                   o_gnt_bus, o_gnt_ch);
        end else begin
          mon_exp = sb[0];
          check("gnt_bus", 32'(o_gnt_bus), 32'(mon_exp.bus));
          check("gnt_ch", 32'(o_gnt_ch), 32'(mon_exp.ch));
          check("gnt_any", 32'(o_gnt_any), 32'(mon_exp.hit));
          if (i_gnt_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin : stimulus
    step();
    step();
    check("rst_req_ready", 32'(o_req_ready), 32'd1);
    check("rst_gnt_valid", 32'(o_gnt_valid), 32'd0);
    check("rst_gnt_bus", 32'(o_gnt_bus), 32'd0);
    check("rst_gnt_ch", 32'(o_gnt_ch), 32'd0);
    check("rst_gnt_any", 32'(o_gnt_any), 32'd0);
    check("rst_unlocked", 32'(o_unlocked), 32'd0);
    check("rst_key_err", 32'(o_key_err), 32'd0);
    i_rst = 1'b0;

    // Key still zero: channel 0 is masked, channel 7 passes.
    drive(1'b1, 27'h1, 9'h1FF, 1'b1, 1'b1, res_t'{bus: 3'b000, ch: 4'd0, hit: 1'b0});
    check("valid_latency", 32'(o_gnt_valid), 32'd1);
    drive(1'b1, 27'h80, 9'h1FF, 1'b1, 1'b1, res_t'{bus: 3'b001, ch: 4'd7, hit: 1'b1});
    step();

    load_key(GOLD, 32, 1'b0);
    check("golden_unlocked", 32'(o_unlocked), 32'd1);
    drive(1'b1, 27'h0042000, 9'h1FF, 1'b1, 1'b1, res_t'{bus: 3'b010, ch: 4'd4, hit: 1'b1});
    drive(1'b1, 27'h0042000, 9'h1EF, 1'b1, 1'b1, res_t'{bus: 3'b100, ch: 4'd0, hit: 1'b1});
    drive(1'b1, 27'h0000000, 9'h1FF, 1'b1, 1'b1, res_t'{bus: 3'b000, ch: 4'd0, hit: 1'b0});
    step();

    load_key(32'h1234_5678, 31, 1'b0);
    check("short_key_err", 32'(o_key_err), 32'd1);
    check("short_key_keeps_unlock", 32'(o_unlocked), 32'd1);
    drive(1'b1, 27'h0042000, 9'h1FF, 1'b1, 1'b1, res_t'{bus: 3'b010, ch: 4'd4, hit: 1'b1});
    step();
    load_key(GOLD, 32, 1'b1);

    // Backpressure: result held three cycles, then drained and refilled in one cycle.
    drive(1'b1, 27'h0000010, 9'h1FF, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      i_req_valid = 1'b1;
      i_req_vec   = 27'h0040000;
      i_gnt_ready = 1'b0;
      #1;
      check("req_ready_stall", 32'(o_req_ready), 32'd0);
      @(posedge i_clk);
      #1;
    end
    drive(1'b1, 27'h0040000, 9'h1FF, 1'b1, 1'b0, '0);
    check("accept_on_drain", 32'(last_acc), 32'd1);
    check("valid_after_refill", 32'(o_gnt_valid), 32'd1);
    step();

    // Held result survives a key change; only later requests see the new key.
    drive(1'b1, 27'h0042000, 9'h1FF, 1'b0, 1'b0, '0);
    load_key(GOLD ^ 32'h0000_0010, 32, 1'b0);
    drive(1'b1, 27'h0042000, 9'h1FF, 1'b1, 1'b0, '0);
    step();

    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < 27; k++) rv[k] = ($urandom_range(0, 4) == 0);
      ren = 9'($urandom) | 9'($urandom);
      drive(1'($urandom_range(0, 3) != 0), rv, ren, 1'($urandom_range(0, 3) != 0), 1'b0, '0);
    end
    i_gnt_ready = 1'b1;
    step();
    step();
    load_key($urandom, 32, 1'b0);
    for (int n = 0; n < 200; n++) begin
      for (int k = 0; k < 27; k++) rv[k] = ($urandom_range(0, 4) == 0);
      ren = 9'($urandom) | 9'($urandom);
      drive(1'($urandom_range(0, 3) != 0), rv, ren, 1'($urandom_range(0, 3) != 0), 1'b0, '0);
    end
    i_gnt_ready = 1'b1;
    step();
    step();
    load_key(GOLD, 32, 1'b0);
    for (int n = 0; n < 200; n++) begin
      for (int k = 0; k < 27; k++) rv[k] = ($urandom_range(0, 4) == 0);
      ren = 9'($urandom) | 9'($urandom);
      drive(1'($urandom_range(0, 3) != 0), rv, ren, 1'($urandom_range(0, 3) != 0), 1'b0, '0);
    end

    // Reset mid-operation drops the held result and relocks.
    i_gnt_ready = 1'b1;
    step();
    step();
    load_key(32'hDEAD_BEEF, 31, 1'b0);
    drive(1'b1, 27'h0042000, 9'h1FF, 1'b0, 1'b0, '0);
    i_rst = 1'b1;
    step();
    sb.delete();
    model_key = '0;
    model_err = 1'b0;
    check("midrst_gnt_valid", 32'(o_gnt_valid), 32'd0);
    check("midrst_req_ready", 32'(o_req_ready), 32'd1);
    check("midrst_unlocked", 32'(o_unlocked), 32'd0);
    check("midrst_key_err", 32'(o_key_err), 32'd0);
    i_rst = 1'b0;
    drive(1'b1, 27'h0042000, 9'h1FF, 1'b1, 1'b0, '0);
    drive(1'b1, 27'h0000100, 9'h1FF, 1'b1, 1'b0, '0);

    i_gnt_ready = 1'b1;
    for (int i = 0; i < 10 && sb.size() > 0; i++) step();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
